// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX,
        WAIT_RX,
        RX,
        HOLD,
        FIN
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef struct packed {
        logic idle_level;
        logic shift_lead;
        logic sample_lead;
    } edge_sel_t;

    // Leading/trailing are already relative to cpol, so only cpha picks the edge roles.
    function automatic edge_sel_t mode_edges(input logic cpol, input logic cpha);
        edge_sel_t e;
        e.idle_level  = cpol;
        e.shift_lead  = cpha;
        e.sample_lead = !cpha;
        return e;
    endfunction

endpackage

// File: rtl/spi_master_multi_clk_gen.sv
// sclk divider: toggles sclk every CLK_DIV enabled cycles and flags leading/trailing edges.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic idle_level,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap       = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign lead_edge  = wrap && (sclk == idle_level);
    assign trail_edge = wrap && (sclk != idle_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= idle_level;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= !sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: runtime CPOL/CPHA, command frame, optional read response with timeout.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned RX_W    = 8,
    parameter int unsigned NUM_SS  = 4,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [1:0]  RD_CMD  = CMD_RD_DATA,
    localparam int unsigned SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] data_in,
    output logic [RX_W-1:0]   data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              MOSI,
    output logic [NUM_SS-1:0] ss_n,
    input  logic              MISO,
    input  logic              valid_MISO,
    input  logic              sready
);
    localparam int unsigned SETUP_LIM = TIMEOUT * 2 * CLK_DIV;
    localparam int unsigned TMR_W     = $clog2(SETUP_LIM + 1);
    localparam int unsigned BC_W      = $clog2(DATA_W + 1);
    localparam int unsigned RXC_W     = $clog2(RX_W + 1);

    state_t            state, next;
    edge_sel_t         sel;
    logic [DATA_W-1:0] tx_shift;
    logic [1:0]        cmd_q;
    logic [SEL_W-1:0]  sel_q;
    logic              cpol_q, cpha_q, err_q;
    logic [BC_W-1:0]   bit_cnt;
    logic [RX_W-1:0]   rx_shift, rx_next;
    logic [RXC_W-1:0]  rx_cnt;
    logic [TMR_W-1:0]  tmr;
    logic              clk_en, idle_level, lead_edge, trail_edge;
    logic              shift_edge, sample_edge, tx_last;

    assign sel         = mode_edges(cpol_q, cpha_q);
    assign shift_edge  = sel.shift_lead  ? lead_edge : trail_edge;
    assign sample_edge = sel.sample_lead ? lead_edge : trail_edge;
    // cpha=0 samples on leading edges, so the count is already 0 by the final trailing edge.
    assign tx_last     = sel.sample_lead ? (bit_cnt == '0) : (bit_cnt == BC_W'(1));
    assign rx_next     = RX_W'({rx_shift, MISO});

    assign clk_en     = (state == TX) || (state == WAIT_RX) || (state == RX);
    assign idle_level = (state == IDLE && start) ? cpol : sel.idle_level;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (clk_en),
        .idle_level (idle_level),
        .sclk       (sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = SETUP;
            SETUP: begin
                if (sready && tmr >= TMR_W'(CLK_DIV - 1))
                    next = TX;
                else if (!sready && tmr == TMR_W'(SETUP_LIM - 1))
                    next = FIN;
            end
            TX:      if (trail_edge && tx_last) next = (cmd_q == RD_CMD) ? WAIT_RX : HOLD;
            WAIT_RX: begin
                if (sample_edge && valid_MISO)
                    next = (RX_W == 1) ? HOLD : RX;
                else if (trail_edge && tmr == TMR_W'(TIMEOUT - 1))
                    next = FIN;
            end
            RX:      if (sample_edge && rx_cnt == RXC_W'(RX_W - 1)) next = HOLD;
            HOLD:    if (tmr == TMR_W'(CLK_DIV - 1)) next = FIN;
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            cmd_q    <= '0;
            sel_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            err_q    <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_cnt   <= '0;
            tmr      <= '0;
            MOSI     <= 1'b0;
            data_out <= '0;
        end else begin
            if (next != state)
                tmr <= '0;
            else if (state == SETUP || state == HOLD || (state == WAIT_RX && trail_edge))
                tmr <= tmr + 1'b1;

            if (state != FIN && next == FIN)
                err_q <= (state != HOLD);

            case (state)
                IDLE: if (start) begin
                    tx_shift <= cpha ? data_in : (data_in << 1);
                    MOSI     <= cpha ? 1'b0 : data_in[DATA_W-1];
                    cmd_q    <= data_in[DATA_W-1 -: 2];
                    sel_q    <= ss_sel;
                    cpol_q   <= cpol;
                    cpha_q   <= cpha;
                    bit_cnt  <= BC_W'(DATA_W);
                end
                TX: begin
                    if (sample_edge)
                        bit_cnt <= bit_cnt - 1'b1;
                    if (next != TX) begin
                        MOSI <= 1'b0;
                    end else if (shift_edge) begin
                        MOSI     <= tx_shift[DATA_W-1];
                        tx_shift <= tx_shift << 1;
                    end
                end
                WAIT_RX: if (sample_edge && valid_MISO) begin
                    rx_shift <= rx_next;
                    rx_cnt   <= RXC_W'(1);
                    if (RX_W == 1) data_out <= rx_next;
                end
                RX: if (sample_edge) begin
                    rx_shift <= rx_next;
                    rx_cnt   <= rx_cnt + 1'b1;
                    if (rx_cnt == RXC_W'(RX_W - 1)) data_out <= rx_next;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);
    assign err  = done && err_q;

    always_comb begin
        ss_n = '1;
        for (int unsigned i = 0; i < NUM_SS; i++)
            ss_n[i] = !(busy && sel_q == SEL_W'(i));
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with an inline SPI slave model (default parameters).
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       rst, start, cpol, cpha, MISO, valid_MISO, sready;
    logic [1:0] ss_sel;
    logic [9:0] data_in;
    logic [7:0] data_out;
    logic       busy, done, err, sclk, MOSI;
    logic [3:0] ss_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transfer observations gathered by run_xfer
    int         done_cyc, done_cnt, bad_edges, multi_low;
    logic       err_d, busy_d, sclk_c4, sclk_after;
    logic [7:0] dout_d;
    logic [3:0] ssn_d, ss_and;
    logic [9:0] mosi_cap;
    logic [7:0] rx_pat = 8'h3C;
    logic [3:0] ab_ssn;
    logic       ab_sclk, ab_busy, ab_done;

    always #5 clk = !clk;

    spi_master_multi #(
        .DATA_W (10),
        .RX_W   (8),
        .NUM_SS (4),
        .CLK_DIV(4),
        .TIMEOUT(64),
        .RD_CMD (2'b11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ss_sel    (ss_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sclk      (sclk),
        .MOSI      (MOSI),
        .ss_n      (ss_n),
        .MISO      (MISO),
        .valid_MISO(valid_MISO),
        .sready    (sready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one transfer, then watches every cycle from the negedge; the slave samples
    // MOSI as it stood just before each rising sclk and drives MISO after falling sclk.
    task automatic run_xfer(input logic [9:0] d, input logic [1:0] sel, input logic pol,
                            input logic pha, input logic drive_rx, input logic spam,
                            input int abort_at);
        logic ps, pm;
        int   rises, falls;
        @(negedge clk);
        data_in = d; ss_sel = sel; cpol = pol; cpha = pha; start = 1'b1;
        valid_MISO = 1'b0; MISO = 1'b0;
        @(posedge clk);
        done_cyc = 0; done_cnt = 0; bad_edges = 0; multi_low = 0;
        mosi_cap = '0; ss_and = '1; rises = 0; falls = 0;
        ps = 1'b0; pm = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (spam && (cyc == 5 || cyc == 40)) begin
                start = 1'b1; data_in = 10'h3FF; ss_sel = 2'd3; cpol = 1'b1; cpha = 1'b1;
            end
            if (cyc > 1) begin
                if (!ps && sclk) begin
                    rises++;
                    if (rises <= 10) mosi_cap = {mosi_cap[8:0], pm};
                end
                if (MOSI != pm && rises < 10 && !(ps && !sclk)) bad_edges++;
                if (ps && !sclk) begin
                    falls++;
                    if (drive_rx) begin
                        if (falls >= 13 && falls <= 20) begin
                            valid_MISO = 1'b1; MISO = rx_pat[20 - falls];
                        end else begin
                            valid_MISO = 1'b0; MISO = 1'b0;
                        end
                    end
                end
            end
            ss_and = ss_and & ss_n;
            if ($countones(~ss_n) > 1) multi_low++;
            if (cyc == 4) sclk_c4 = sclk;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc; err_d = err; busy_d = busy; dout_d = data_out; ssn_d = ss_n;
                end
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) sclk_after = sclk;
            if (abort_at != 0 && cyc == abort_at) rst = 1'b1;
            if (abort_at != 0 && cyc == abort_at + 1) begin
                rst = 1'b0;
                ab_ssn = ss_n; ab_sclk = sclk; ab_busy = busy; ab_done = done;
                break;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 10) break;
            ps = sclk; pm = MOSI;
        end
        valid_MISO = 1'b0; MISO = 1'b0;
    endtask

    initial begin
        int extra_done;
        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; ss_sel = '0; data_in = '0;
        MISO = 1'b0; valid_MISO = 1'b0; sready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        rst = 1'b0;

        // Mode 0 write to slave 2
        run_xfer(10'h0A5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("m0w_done_cyc", 32'(done_cyc), 32'd89);
        check("m0w_err",      32'(err_d), 32'd0);
        check("m0w_busy",     32'(busy_d), 32'd0);
        check("m0w_mosi",     32'(mosi_cap), 32'h0A5);
        check("m0w_ss_seen",  32'(ss_and), 32'hB);
        check("m0w_multi",    32'(multi_low), 32'd0);
        check("m0w_edges",    32'(bad_edges), 32'd0);
        check("m0w_ndone",    32'(done_cnt), 32'd1);

        // Mode 0 read: valid_MISO after 3 wait periods, response 0x3C
        run_xfer(10'h300, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("rd_done_cyc", 32'(done_cyc), 32'd173);
        check("rd_dout",     32'(dout_d), 32'h3C);
        check("rd_busy",     32'(busy_d), 32'd0);
        check("rd_err",      32'(err_d), 32'd0);
        check("rd_ss_fin",   32'(ssn_d), 32'hF);

        // Mode 3 write to slave 1
        run_xfer(10'h2A5, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("m3_sclk_setup", 32'(sclk_c4), 32'd1);
        check("m3_sclk_after", 32'(sclk_after), 32'd1);
        check("m3_mosi",       32'(mosi_cap), 32'h2A5);
        check("m3_edges",      32'(bad_edges), 32'd0);
        check("m3_done_cyc",   32'(done_cyc), 32'd89);
        check("m3_ss_seen",    32'(ss_and), 32'hD);

        // Read with valid_MISO never asserted
        run_xfer(10'h3FF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("to_done_cyc", 32'(done_cyc), 32'd597);
        check("to_err",      32'(err_d), 32'd1);
        check("to_dout",     32'(dout_d), 32'h3C);
        check("to_ss_fin",   32'(ssn_d), 32'hF);
        check("to_ndone",    32'(done_cnt), 32'd1);

        // sready held low: SETUP timeout after TIMEOUT*2*CLK_DIV cycles
        sready = 1'b0;
        run_xfer(10'h0F0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        sready = 1'b1;
        check("srdy_done_cyc", 32'(done_cyc), 32'd513);
        check("srdy_err",      32'(err_d), 32'd1);

        // start re-pulsed at cycles 5 and 40 must be ignored
        run_xfer(10'h155, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("spam_ndone",    32'(done_cnt), 32'd1);
        check("spam_done_cyc", 32'(done_cyc), 32'd89);
        check("spam_mosi",     32'(mosi_cap), 32'h155);
        check("spam_ss_seen",  32'(ss_and), 32'hE);

        // Reset at cycle 30 of a mode 3 transfer (sclk high there)
        run_xfer(10'h0A5, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 30);
        check("ab_ss_n", 32'(ab_ssn), 32'hF);
        check("ab_sclk", 32'(ab_sclk), 32'd0);
        check("ab_busy", 32'(ab_busy), 32'd0);
        check("ab_done", 32'(ab_done), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("ab_no_done", 32'(extra_done), 32'd0);

        run_xfer(10'h1C3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("post_done_cyc", 32'(done_cyc), 32'd89);
        check("post_mosi",     32'(mosi_cap), 32'h1C3);
        check("post_err",      32'(err_d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master, next generation of the single-slave, fixed-mode master. Adds configurable frame widths, NUM_SS decoded slave selects, and runtime CPOL/CPHA (modes 0-3). Adds a programmable sclk divider and a read-response wait phase with timeout/error reporting. Sits between the system controller and up to NUM_SS SPI slaves (RAM-style slaves using the 2-bit command + payload frame).

Parameters:
DATA_W, 10, TX frame width in bits; MSBs [DATA_W-1:DATA_W-2] are the command.
RX_W, 8, read-response width in bits.
NUM_SS, 4, number of slave-select lines (>=1).
CLK_DIV, 4, clk cycles per sclk half-period (>=2).
TIMEOUT, 64, max sclk periods spent waiting for sready or valid_MISO.
RD_CMD, 2'b11, command value that triggers the read-response phase.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; honoured only when busy=0
ss_sel  in  $clog2(NUM_SS) (min 1)  target slave, latched on start
cpol  in  1  clock polarity, latched on start
cpha  in  1  clock phase, latched on start
data_in  in  DATA_W  TX frame, latched on start
data_out  out  RX_W  last read response, held until next read completes
busy  out  1  high from cycle after start until done cycle
done  out  1  one-cycle pulse at transfer end (success or error)
err  out  1  one-cycle pulse coincident with done on timeout
sclk  out  1  SPI clock
MOSI  out  1  serial data out, MSB first
ss_n  out  NUM_SS  active-low selects; at most one low at any time
MISO  in  1  serial data in
valid_MISO  in  1  slave flag: MISO carries response bits
sready  in  1  slave ready

Behaviour:
- Reset (synchronous, rst=1 on a clk edge): state IDLE; sclk=0; MOSI=0; ss_n all 1; busy, done, err = 0; data_out=0; latched cpol/cpha=0. Reset mid-transfer aborts immediately: ss_n high on the next edge, no done pulse.
- FSM states: IDLE, SETUP, TX, WAIT_RX, RX, HOLD, FIN.
- IDLE:
  - sclk = latched cpol.
  - On start: latch data_in, ss_sel, cpol, cpha; go to SETUP.
  - start while busy is ignored, with no side effects.
- SETUP:
  - Entered at cycle 1: ss_n[ss_sel]=0; busy=1.
  - If cpha=0, MOSI=data_in[DATA_W-1].
  - Stay in SETUP until sready=1, for at least CLK_DIV cycles.
  - If sready stays low for TIMEOUT*2*CLK_DIV cycles, go to FIN with err.
- Divider: counter 0..CLK_DIV-1; sclk toggles on wrap while in TX, WAIT_RX or RX.
  - Leading edge = first toggle away from cpol.
- Edge rules:
  - cpha=0: master shifts MOSI on the trailing edge; samples MISO on the leading edge.
  - cpha=1: master shifts MOSI on the leading edge; samples MISO on the trailing edge.
- TX:
  - Exactly DATA_W sclk periods.
  - Bit counter decrements on each sample edge.
  - Exit on the final trailing edge: to WAIT_RX if cmd==RD_CMD, else HOLD.
- WAIT_RX:
  - sclk keeps toggling; MOSI=0.
  - On the first sample edge with valid_MISO=1, that bit is RX bit RX_W-1; go to RX.
  - After TIMEOUT sclk periods with no valid_MISO: go to FIN with err; data_out unchanged.
- RX:
  - Shift MISO into rx_shift on sample edges, RX_W bits total, MSB first.
  - valid_MISO low mid-frame is ignored (bit still sampled).
  - On last bit: data_out <= rx_shift; go to HOLD.
- HOLD: sclk at cpol for CLK_DIV cycles; ss_n still asserted.
- FIN:
  - One cycle: ss_n all 1; done=1; busy=0; err as flagged.
  - Next cycle: IDLE. A start in the FIN cycle is ignored.
- Write latency, sready already high: done asserts at cycle 1 + CLK_DIV*(2 + 2*DATA_W) after the start cycle. Default parameters give 89.
- ss_sel >= NUM_SS: no line asserted; transfer runs normally. This is legal for bus-idle timing.

Decomposition:
- Package spi_pkg:
  - state_t enum.
  - Command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Function mode_edges(cpol, cpha) returning the shift/sample edge select.
- Sub-module spi_clk_gen: divider counter, sclk register, and one-cycle lead_edge/trail_edge strobes; enabled by the FSM.

Test Plan:
- Mode 0 write, data_in=10'b00_1010_0101, ss_sel=2, sready=1:
  - MOSI on leading edges is 0,0,1,0,1,0,0,1,0,1.
  - Only ss_n[2] goes low.
  - done at cycle 89; err=0.
- Mode 0 read, data_in=10'b11_0000_0000: slave asserts valid_MISO after 3 sclk periods and drives 0x3C -> data_out=8'h3C at done; busy low in the same cycle.
- Mode 3 (cpol=1, cpha=1) write, data_in=10'h2A5:
  - sclk idles high before and after.
  - MOSI changes on falling edges; slave sampling on rising edges recovers 10'h2A5.
- Read with valid_MISO never asserted -> after 64 sclk periods, done=1 and err=1 in the same cycle; data_out keeps its previous value; ss_n all high.
- start pulsed again at cycles 5 and 40 of an active transfer -> ignored: exactly one done, latched data unchanged.
- rst=1 at cycle 30 of a transfer -> next edge: ss_n all 1, sclk=0, busy=0, no done; a fresh start afterwards completes normally.
